pe_linear_mac_ctrl: RTL and testbench



---
 rtl/pe_linear_pkg.sv | 18 +
 rtl/pe_tag_delay.sv | 35 +++
 rtl/pe_linear_mac_ctrl.sv | 114 +++++++++++
 tb/tb_pe_linear_mac_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pe_linear_pkg.sv
// pe_linear_pkg: shared types and derived constants for the linear-layer MAC controller and datapath
// Contents: FSM state enum, group/beat/latency helper functions, activation-name constants.
package pe_linear_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_HOLD, S_DRAIN, S_POST, S_OUT} state_t;
    localparam string ACT_SIGMOID = "sigmoid";
    localparam string ACT_RELU = "relu";
    localparam string ACT_NONE = "none";
    localparam string ACT_SOFTMAX = "softmax";
    function automatic int calc_groups(input int out_feature, input int parallel);
        return out_feature / parallel;
    endfunction
    function automatic int calc_beats(input int in_feature, input int channel);
        return in_feature / channel;
    endfunction
    function automatic int calc_mac_lat(input int ram_lat, input int dsp_lat, input int adder_lat);
        return ram_lat + dsp_lat + adder_lat;
    endfunction
endpackage

// File: rtl/pe_tag_delay.sv
// pe_tag_delay: fixed-depth shift line carrying a valid bit and a tag, synchronous reset
// Ports: valid/tag enter each cycle; dly_valid/dly_tag emerge pDEPTH cycles later;
//        pending flags any entry still in flight other than the one currently emerging.
module pe_tag_delay #(
    parameter int pDEPTH = 4,
    parameter int pTAG_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [pTAG_W-1:0] tag,
    output logic              dly_valid,
    output logic [pTAG_W-1:0] dly_tag,
    output logic              pending
);
    localparam logic [pDEPTH-1:0] MASK = {pDEPTH{1'b1}} >> 1;
    logic [pDEPTH-1:0] vld;
    logic [pTAG_W-1:0] tags [pDEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < pDEPTH; i++) tags[i] <= '0;
        end else begin
            vld[0] <= valid;
            tags[0] <= tag;
            for (int i = 1; i < pDEPTH; i++) begin
                vld[i] <= vld[i-1];
                tags[i] <= tags[i-1];
            end
        end
    end
    assign dly_valid = vld[pDEPTH-1];
    assign dly_tag = tags[pDEPTH-1];
    assign pending = |(vld & MASK);
endmodule

// File: rtl/pe_linear_mac_ctrl.sv
// pe_linear_mac_ctrl: beat sequencer for the linear-layer MAC datapath
// Ports: in_valid/in_ready beat handshake, out_valid/out_ready result handshake,
//        load_weight monitor with sticky err_load, kernel_addr weight-RAM address,
//        out_feature/mac_en aligned to the MAC pipeline, post-stage enables, clr on accept.
module pe_linear_mac_ctrl
    import pe_linear_pkg::*;
#(
    parameter int pIN_FEATURE = 14*14*32,
    parameter int pOUT_FEATURE = 128,
    parameter int pCHANNEL = 32,
    parameter int pOUTPUT_PARALLEL = 4,
    parameter int pKERNEL_NUM = 4000,
    parameter int pRAM_LATENCY = 1,
    parameter int pDSP_LATENCY = 1,
    parameter int pADDER_LATENCY = $clog2(pCHANNEL),
    parameter int pDEQUANT_LATENCY = 1,
    parameter int pACT_LATENCY = 1,
    parameter int pQUANT_LATENCY = 1,
    parameter string pACTIVATION = "sigmoid"
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    input  logic load_weight,
    output logic busy,
    output logic err_load,
    output logic clr,
    output logic [$clog2(pKERNEL_NUM)-1:0] kernel_addr,
    output logic [$clog2(pOUT_FEATURE/pOUTPUT_PARALLEL)-1:0] out_feature,
    output logic dsp_en,
    output logic adder_en,
    output logic mac_en,
    output logic dequant_en,
    output logic bias_en,
    output logic act_en,
    output logic quant_en
);
    localparam int G = calc_groups(pOUT_FEATURE, pOUTPUT_PARALLEL);
    localparam int B = calc_beats(pIN_FEATURE, pCHANNEL);
    localparam int MAC_LAT = calc_mac_lat(pRAM_LATENCY, pDSP_LATENCY, pADDER_LATENCY);
    localparam bit SOFTMAX = (pACTIVATION == ACT_SOFTMAX);
    localparam bit NO_ACT = SOFTMAX || (pACTIVATION == ACT_NONE);
    // softmax leaves POST straight after bias; otherwise the chain runs through quant
    localparam int POST_LEN = SOFTMAX ? pDEQUANT_LATENCY + 1
                                      : pDEQUANT_LATENCY + 1 + pACT_LATENCY + pQUANT_LATENCY;
    localparam int KW = $clog2(pKERNEL_NUM);
    localparam int GW = $clog2(G);
    localparam int BW = $clog2(B + 1);
    localparam int CW = $clog2(G + pRAM_LATENCY + POST_LEN + 1);

    if (G * pOUTPUT_PARALLEL != pOUT_FEATURE || B * pCHANNEL != pIN_FEATURE || B * G > pKERNEL_NUM) begin : g_bad_cfg
        $error("pe_linear_mac_ctrl: inexact feature division or weight RAM too small");
    end

    state_t state, nxt;
    logic [BW-1:0] b;
    logic [CW-1:0] cnt;
    logic hold_last, pending;

    pe_tag_delay #(.pDEPTH(MAC_LAT), .pTAG_W(GW)) u_tag_delay (
        .clk(clk),
        .rst(rst),
        .valid(state == S_ISSUE),
        .tag(GW'(cnt)),
        .dly_valid(mac_en),
        .dly_tag(out_feature),
        .pending(pending)
    );

    // HOLD stalls on its last cycle while load_weight blocks the acknowledge
    assign hold_last = state == S_HOLD && cnt == CW'(pRAM_LATENCY - 1);
    assign in_ready = hold_last && !load_weight;
    assign busy = state != S_IDLE;
    assign dsp_en = busy && state != S_OUT;
    assign adder_en = dsp_en;
    assign out_valid = state == S_OUT;
    assign clr = out_valid && out_ready;
    assign dequant_en = state == S_POST && cnt == '0;
    assign bias_en = state == S_POST && cnt == CW'(pDEQUANT_LATENCY);
    assign act_en = !NO_ACT && state == S_POST && cnt == CW'(pDEQUANT_LATENCY + 1);
    assign quant_en = !SOFTMAX && state == S_POST && cnt == CW'(pDEQUANT_LATENCY + 1 + pACT_LATENCY);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_WAIT: if (in_valid && !load_weight) nxt = S_ISSUE;
            S_ISSUE: if (cnt == CW'(G - 1)) nxt = S_HOLD;
            S_HOLD: if (in_ready) nxt = (b == BW'(B - 1)) ? S_DRAIN : S_WAIT;
            S_DRAIN: if (!pending) nxt = S_POST;
            S_POST: if (cnt == CW'(POST_LEN - 1)) nxt = S_OUT;
            S_OUT: if (out_ready) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            b <= '0;
            cnt <= '0;
            kernel_addr <= '0;
            err_load <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= (nxt != state) ? '0 : hold_last ? cnt : cnt + CW'(1);
            b <= clr ? '0 : in_ready ? b + BW'(1) : b;
            if (nxt == S_ISSUE) kernel_addr <= (state == S_ISSUE) ? kernel_addr + KW'(1) : KW'(b) * KW'(G);
            err_load <= err_load | (load_weight & busy);
        end
    end
endmodule

// File: tb/tb_pe_linear_mac_ctrl.sv
// tb_pe_linear_mac_ctrl: randomized event-schedule check of the MAC controller (sigmoid and softmax instances)
module tb_pe_linear_mac_ctrl;
    localparam int G = 2;
    localparam int B = 2;
    localparam int ML = 4;
    localparam int RL = 1;
    localparam int DQ = 1;
    localparam int AL = 1;
    localparam int QL = 1;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, load_weight;
    logic in_ready, out_valid, busy, err_load, clr, dsp_en, adder_en, mac_en;
    logic dequant_en, bias_en, act_en, quant_en;
    logic [11:0] kernel_addr;
    logic [0:0] out_feature;
    logic in_ready_s, out_valid_s, busy_s, err_load_s, clr_s, dsp_en_s, adder_en_s, mac_en_s;
    logic dequant_en_s, bias_en_s, act_en_s, quant_en_s;
    logic [11:0] kernel_addr_s;
    logic [0:0] out_feature_s;
    logic [11:0] obs, obs_s;
    int checks = 0;
    int errors = 0;
    int exp_ka = 0;
    bit exp_err = 0;

    always #5 clk = ~clk;

    pe_linear_mac_ctrl #(.pIN_FEATURE(8), .pOUT_FEATURE(8), .pCHANNEL(4), .pOUTPUT_PARALLEL(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .load_weight(load_weight), .busy(busy), .err_load(err_load), .clr(clr),
        .kernel_addr(kernel_addr), .out_feature(out_feature), .dsp_en(dsp_en), .adder_en(adder_en),
        .mac_en(mac_en), .dequant_en(dequant_en), .bias_en(bias_en), .act_en(act_en), .quant_en(quant_en)
    );

    pe_linear_mac_ctrl #(.pIN_FEATURE(8), .pOUT_FEATURE(8), .pCHANNEL(4), .pOUTPUT_PARALLEL(4),
                         .pACTIVATION("softmax")) u_smax (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .load_weight(load_weight), .busy(busy_s), .err_load(err_load_s), .clr(clr_s),
        .kernel_addr(kernel_addr_s), .out_feature(out_feature_s), .dsp_en(dsp_en_s), .adder_en(adder_en_s),
        .mac_en(mac_en_s), .dequant_en(dequant_en_s), .bias_en(bias_en_s), .act_en(act_en_s), .quant_en(quant_en_s)
    );

    assign obs = {in_ready, busy, dsp_en, adder_en, mac_en, dequant_en, bias_en, act_en, quant_en, out_valid, clr, err_load};
    assign obs_s = {in_ready_s, busy_s, dsp_en_s, adder_en_s, mac_en_s, dequant_en_s, bias_en_s, act_en_s, quant_en_s,
                    out_valid_s, clr_s, err_load_s};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_ctrl", 32'(obs), 32'(0));
        check("rst_ctrl_smax", 32'(obs_s), 32'(0));
        check("rst_kernel_addr", 32'(kernel_addr), 32'(0));
        check("rst_kernel_addr_smax", 32'(kernel_addr_s), 32'(0));
        check("rst_out_feature", 32'(out_feature), 32'(0));
        check("rst_out_feature_smax", 32'(out_feature_s), 32'(0));
    endtask

    // One input vector: the schedule is derived from the beat timing rules, then every cycle is compared.
    task automatic run_vector(input int gap0, input int gap1, input int rd, input bit lw_issue,
                              input bit iv_out, input int abort);
        int v[B];
        int s[B];
        int r[B];
        int last_mac, o0, o1, acc, n;
        for (int k = 0; k < B; k++) begin
            if (k == 0) v[k] = gap0;
            else v[k] = r[k-1] + 1 + gap1;
            s[k] = v[k];
            r[k] = s[k] + G + RL;
        end
        last_mac = s[B-1] + G + ML;
        o0 = last_mac + 2 + DQ + AL + QL;
        o1 = last_mac + 2 + DQ;
        acc = o0 + rd;
        n = (abort >= 0) ? abort + 1 : acc + 1;
        for (int c = 0; c < n; c++) begin
            bit iv, rdy, mac, bsy;
            int tag;
            logic [11:0] e0, e1;
            @(posedge clk);
            #1;
            iv = iv_out && c >= o0;
            for (int k = 0; k < B; k++) if (c >= v[k] && c <= r[k]) iv = 1;
            in_valid = iv;
            out_ready = c >= acc;
            load_weight = lw_issue && c == s[0] + 1;
            rst = c == abort;
            @(negedge clk);
            rdy = 0;
            mac = 0;
            tag = 0;
            for (int k = 0; k < B; k++) begin
                if (c == r[k]) rdy = 1;
                for (int g = 0; g < G; g++) begin
                    if (c == s[k] + 1 + g) exp_ka = k * G + g;
                    if (c == s[k] + 1 + g + ML) begin
                        mac = 1;
                        tag = g;
                    end
                end
            end
            bsy = c > s[0] && c <= acc;
            e0 = {rdy, bsy, bsy && c < o0, bsy && c < o0, mac, c == last_mac + 1, c == last_mac + 1 + DQ,
                  c == last_mac + 2 + DQ, c == last_mac + 2 + DQ + AL, c >= o0 && c <= acc, c == acc, exp_err};
            e1 = {rdy, bsy, bsy && c < o1, bsy && c < o1, mac, c == last_mac + 1, c == last_mac + 1 + DQ,
                  1'b0, 1'b0, c >= o1 && c <= acc, c == acc, exp_err};
            check("ctrl", 32'(obs), 32'(e0));
            check("ctrl_smax", 32'(obs_s), 32'(e1));
            check("kernel_addr", 32'(kernel_addr), exp_ka);
            check("kernel_addr_smax", 32'(kernel_addr_s), exp_ka);
            if (mac) begin
                check("out_feature", 32'(out_feature), tag);
                check("out_feature_smax", 32'(out_feature_s), tag);
            end
            if (load_weight && bsy) exp_err = 1;
        end
        if (abort >= 0) begin
            @(posedge clk);
            #1;
            rst = 0;
            in_valid = 0;
            load_weight = 0;
            out_ready = 0;
            exp_ka = 0;
            exp_err = 0;
            @(negedge clk);
            check_reset_state();
        end
    endtask

    initial begin
        bit prev_iv;
        int g0, g1, rd;
        bit ivo;
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        load_weight = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check_reset_state();
        run_vector(0, 0, 0, 0, 0, -1);
        run_vector(0, 0, 5, 0, 1, -1);
        run_vector(0, 3, 0, 0, 0, -1);
        repeat (3) begin
            @(posedge clk);
            #1;
            in_valid = 1;
            load_weight = 1;
            @(negedge clk);
            check("lw_idle_ready", 32'(in_ready), 32'(0));
            check("lw_idle_busy", 32'(busy), 32'(0));
            check("lw_idle_err", 32'(err_load), 32'(0));
            check("lw_idle_kernel_addr", 32'(kernel_addr), exp_ka);
        end
        run_vector(0, 1, 2, 1, 0, -1);
        run_vector(2, 0, 1, 0, 0, -1);
        run_vector(0, 0, 0, 0, 0, 6);
        run_vector(1, 2, 3, 0, 0, -1);
        prev_iv = 0;
        for (int i = 0; i < 8; i++) begin
            g0 = prev_iv ? 0 : int'($urandom_range(0, 3));
            g1 = int'($urandom_range(0, 3));
            rd = int'($urandom_range(0, 4));
            ivo = 1'($urandom_range(0, 1));
            run_vector(g0, g1, rd, 0, ivo, -1);
            prev_iv = ivo;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
